// File: rtl/oled_power_seq_core.sv
// Power-up/power-down sequencer for the PmodOLED (SSD1306) panel: drives the
// supply/reset/dc pins and feeds fixed command bytes to the shared SPI master.
module oled_power_seq_core #(
    parameter int unsigned CYCLES_PER_MS = 100000,
    parameter int unsigned T_VDD_MS      = 1,
    parameter int unsigned T_RST_MS      = 1,
    parameter int unsigned T_VBAT_MS     = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        oled_dc,
    output logic        oled_reset,
    output logic        oled_vbatc,
    output logic        oled_vddc,
    output logic        spi_own,
    output logic        spi_req,
    output logic [7:0]  spi_byte,
    input  logic        spi_ack
);
    typedef enum logic [3:0] {
        S_OFF           = 4'd0,
        S_VDD_WAIT      = 4'd1,
        S_CMD_AE        = 4'd2,
        S_RST_LOW       = 4'd3,
        S_CMD_INIT      = 4'd4,
        S_VBAT_WAIT     = 4'd5,
        S_CMD_AF        = 4'd6,
        S_ON            = 4'd7,
        S_CMD_OFF       = 4'd8,
        S_VBAT_OFF_WAIT = 4'd9,
        S_VDD_OFF       = 4'd10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pre;
    logic [31:0] r_ms;
    logic [31:0] w_wait_ms;
    logic        w_wait_done;
    logic [2:0]  r_idx;
    logic [2:0]  w_byte_cnt;
    logic        r_gap;
    logic        w_bytes_done;
    logic        w_reject;
    logic        w_entry;
    logic        r_rejected;
    logic        r_dc;
    logic        r_reset;
    logic        r_vbatc;
    logic        r_vddc;
    logic        r_own;
    logic        r_req;
    logic [7:0]  r_byte;
    logic        w_wr_en;
    logic        w_ctrl_wr;
    logic        w_dc_wr;
    logic        w_clr_wr;
    logic        w_unused;

    function automatic logic [7:0] cmd_byte(input state_t s, input logic [2:0] idx);
        logic [7:0] b;
        case (s)
            S_CMD_AE, S_CMD_OFF: b = 8'hAE;
            S_CMD_AF:            b = 8'hAF;
            S_CMD_INIT: begin
                case (idx)
                    3'd0:    b = 8'h8D;
                    3'd1:    b = 8'h14;
                    3'd2:    b = 8'hD9;
                    3'd3:    b = 8'hF1;
                    default: b = 8'h00;
                endcase
            end
            default:             b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic is_cmd(input state_t s);
        return (s == S_CMD_AE) || (s == S_CMD_INIT) || (s == S_CMD_AF) || (s == S_CMD_OFF);
    endfunction

    assign w_wr_en   = cs & write;
    assign w_ctrl_wr = w_wr_en && (addr[1:0] == 2'd0);
    assign w_dc_wr   = w_wr_en && (addr[1:0] == 2'd1);
    assign w_clr_wr  = w_wr_en && (addr[1:0] == 2'd2);
    assign w_unused  = &{1'b0, read, addr[4:2], wr_data[31:2]};

    // Per-state wait length and command list length.
    always_comb begin
        w_wait_ms  = 32'd0;
        w_byte_cnt = 3'd1;
        case (r_state)
            S_VDD_WAIT:                   w_wait_ms = T_VDD_MS;
            S_RST_LOW:                    w_wait_ms = T_RST_MS;
            S_VBAT_WAIT, S_VBAT_OFF_WAIT: w_wait_ms = T_VBAT_MS;
            S_CMD_INIT:                   w_byte_cnt = 3'd4;
            default:                      w_wait_ms = 32'd0;
        endcase
    end

    // A zero-length wait still occupies one cycle.
    assign w_wait_done  = (w_wait_ms == 32'd0) ||
                          ((r_ms == w_wait_ms - 32'd1) && (r_pre == CYCLES_PER_MS - 32'd1));
    assign w_bytes_done = r_gap && (r_idx == w_byte_cnt);
    assign w_entry      = (w_state_nxt != r_state);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and request rejection; power_off wins when both bits are set.
    always_comb begin
        w_state_nxt = r_state;
        w_reject    = 1'b0;
        if (w_ctrl_wr && wr_data[1]) begin
            w_reject = (r_state != S_ON);
        end else if (w_ctrl_wr && wr_data[0]) begin
            w_reject = (r_state != S_OFF);
        end else begin
            w_reject = 1'b0;
        end
        case (r_state)
            S_OFF:           if (w_ctrl_wr && wr_data[0] && !wr_data[1]) w_state_nxt = S_VDD_WAIT;
                             else w_state_nxt = S_OFF;
            S_VDD_WAIT:      if (w_wait_done) w_state_nxt = S_CMD_AE; else w_state_nxt = r_state;
            S_CMD_AE:        if (w_bytes_done) w_state_nxt = S_RST_LOW; else w_state_nxt = r_state;
            S_RST_LOW:       if (w_wait_done) w_state_nxt = S_CMD_INIT; else w_state_nxt = r_state;
            S_CMD_INIT:      if (w_bytes_done) w_state_nxt = S_VBAT_WAIT; else w_state_nxt = r_state;
            S_VBAT_WAIT:     if (w_wait_done) w_state_nxt = S_CMD_AF; else w_state_nxt = r_state;
            S_CMD_AF:        if (w_bytes_done) w_state_nxt = S_ON; else w_state_nxt = r_state;
            S_ON:            if (w_ctrl_wr && wr_data[1]) w_state_nxt = S_CMD_OFF;
                             else w_state_nxt = S_ON;
            S_CMD_OFF:       if (w_bytes_done) w_state_nxt = S_VBAT_OFF_WAIT; else w_state_nxt = r_state;
            S_VBAT_OFF_WAIT: if (w_wait_done) w_state_nxt = S_VDD_OFF; else w_state_nxt = r_state;
            S_VDD_OFF:       w_state_nxt = S_OFF;
            default:         w_state_nxt = S_OFF;
        endcase
    end

    // Timers, byte handshake, pins and status flag; all keyed off state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre      <= 32'd0;
            r_ms       <= 32'd0;
            r_idx      <= 3'd0;
            r_gap      <= 1'b0;
            r_req      <= 1'b0;
            r_byte     <= 8'h00;
            r_own      <= 1'b0;
            r_vddc     <= 1'b1;
            r_vbatc    <= 1'b1;
            r_reset    <= 1'b1;
            r_dc       <= 1'b0;
            r_rejected <= 1'b0;
        end else begin
            if (w_entry) begin
                r_pre <= 32'd0;
                r_ms  <= 32'd0;
            end else if (r_pre == CYCLES_PER_MS - 32'd1) begin
                r_pre <= 32'd0;
                r_ms  <= r_ms + 32'd1;
            end else begin
                r_pre <= r_pre + 32'd1;
            end

            if (w_entry) begin
                r_idx <= 3'd0;
                r_gap <= 1'b0;
                r_req <= is_cmd(w_state_nxt);
                if (is_cmd(w_state_nxt)) begin
                    r_byte <= cmd_byte(w_state_nxt, 3'd0);
                end else begin
                    r_byte <= r_byte;
                end
            end else if (r_req && spi_ack) begin
                r_req <= 1'b0;
                r_gap <= 1'b1;
                r_idx <= r_idx + 3'd1;
            end else if (r_gap) begin
                r_gap  <= 1'b0;
                r_req  <= 1'b1;
                r_byte <= cmd_byte(r_state, r_idx);
            end else begin
                r_req <= r_req;
            end

            if (w_entry) begin
                case (w_state_nxt)
                    S_VDD_WAIT:      r_vddc  <= 1'b0;
                    S_RST_LOW:       r_reset <= 1'b0;
                    S_CMD_INIT:      r_reset <= 1'b1;
                    S_VBAT_WAIT:     r_vbatc <= 1'b0;
                    S_VBAT_OFF_WAIT: r_vbatc <= 1'b1;
                    S_VDD_OFF:       r_vddc  <= 1'b1;
                    default:         r_vddc  <= r_vddc;
                endcase
            end else begin
                r_vddc <= r_vddc;
            end

            if (w_state_nxt != S_ON) begin
                r_dc <= 1'b0;
            end else if (w_dc_wr && (r_state == S_ON)) begin
                r_dc <= wr_data[0];
            end else begin
                r_dc <= r_dc;
            end

            r_own <= (w_state_nxt != S_OFF) && (w_state_nxt != S_ON);

            if (w_clr_wr) begin
                r_rejected <= 1'b0;
            end else if (w_reject) begin
                r_rejected <= 1'b1;
            end else begin
                r_rejected <= r_rejected;
            end
        end
    end

    assign rd_data    = {21'd0, r_rejected, (r_state == S_ON),
                         (r_state != S_OFF) && (r_state != S_ON), 4'd0, r_state};
    assign oled_dc    = r_dc;
    assign oled_reset = r_reset;
    assign oled_vbatc = r_vbatc;
    assign oled_vddc  = r_vddc;
    assign spi_own    = r_own;
    assign spi_req    = r_req;
    assign spi_byte   = r_byte;
endmodule

// File: tb/tb_oled_power_seq_core.sv
// Directed bench for oled_power_seq_core with a small SPI ack model and an
// event log of request edges and pin transitions.
module tb_oled_power_seq_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic        oled_dc, oled_reset, oled_vbatc, oled_vddc;
    logic        spi_own, spi_req, spi_ack;
    logic [7:0]  spi_byte;

    logic model_ack = 1'b0;
    logic stray_ack = 1'b0;
    logic slow_14 = 1'b0;
    assign spi_ack = model_ack | stray_ack;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    int q_rise[$];
    int q_fall[$];
    int q_byte[$];
    int q_dc[$];
    int t_vdd_fall, t_vdd_rise, t_rst_fall, t_rst_rise, t_vbat_fall, t_vbat_rise;
    logic prev_req, prev_vdd, prev_vbat, prev_rst;
    logic ack_pending = 1'b0;
    int   ack_cnt = 0;

    oled_power_seq_core #(
        .CYCLES_PER_MS(10), .T_VDD_MS(1), .T_RST_MS(2), .T_VBAT_MS(3)
    ) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .oled_dc(oled_dc), .oled_reset(oled_reset), .oled_vbatc(oled_vbatc),
        .oled_vddc(oled_vddc), .spi_own(spi_own), .spi_req(spi_req),
        .spi_byte(spi_byte), .spi_ack(spi_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event log plus SPI model: ack seen at the 4th edge after the req rise.
    always @(negedge clk) begin
        if (prev_req === 1'b0 && spi_req === 1'b1) begin
            q_rise.push_back(cyc);
            q_byte.push_back(int'(spi_byte));
            q_dc.push_back(int'(oled_dc));
        end
        if (prev_req === 1'b1 && spi_req === 1'b0) q_fall.push_back(cyc);
        if (prev_vdd === 1'b1 && oled_vddc === 1'b0) t_vdd_fall = cyc;
        if (prev_vdd === 1'b0 && oled_vddc === 1'b1) t_vdd_rise = cyc;
        if (prev_rst === 1'b1 && oled_reset === 1'b0) t_rst_fall = cyc;
        if (prev_rst === 1'b0 && oled_reset === 1'b1) t_rst_rise = cyc;
        if (prev_vbat === 1'b1 && oled_vbatc === 1'b0) t_vbat_fall = cyc;
        if (prev_vbat === 1'b0 && oled_vbatc === 1'b1) t_vbat_rise = cyc;
        model_ack = 1'b0;
        if (ack_pending) begin
            if (ack_cnt == 0) begin
                model_ack   = 1'b1;
                ack_pending = 1'b0;
            end else begin
                ack_cnt--;
            end
        end
        if (prev_req === 1'b0 && spi_req === 1'b1) begin
            ack_pending = 1'b1;
            ack_cnt     = (slow_14 && spi_byte == 8'h14) ? 48 : 2;
        end
        prev_req  = spi_req;
        prev_vdd  = oled_vddc;
        prev_vbat = oled_vbatc;
        prev_rst  = oled_reset;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rise_at(input int i);
        if (i < q_rise.size()) return q_rise[i];
        return -1000;
    endfunction
    function automatic int fall_at(input int i);
        if (i < q_fall.size()) return q_fall[i];
        return -1000;
    endfunction
    function automatic int byte_at(input int i);
        if (i < q_byte.size()) return q_byte[i];
        return -1;
    endfunction

    task automatic clear_log();
        q_rise.delete();
        q_fall.delete();
        q_byte.delete();
        q_dc.delete();
        t_vdd_fall = -1; t_vdd_rise = -1; t_rst_fall = -1;
        t_rst_rise = -1; t_vbat_fall = -1; t_vbat_rise = -1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
        int n = 0;
        while (rd_data[3:0] !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {28'd0, rd_data[3:0]}, {28'd0, s});
    endtask

    task automatic check_on_bytes(input string tag);
        logic [7:0] exp_b [6] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hAF};
        check({tag, "_nbytes"}, q_byte.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_byte%0d", tag, i), byte_at(i), {24'd0, exp_b[i]});
    endtask

    task automatic check_on_timing(input string tag);
        check({tag, "_vdd_to_ae"}, rise_at(0) - t_vdd_fall, 32'd10);
        check({tag, "_ae_to_rst"}, t_rst_fall - rise_at(0), 32'd5);
        check({tag, "_rst_low"}, t_rst_rise - t_rst_fall, 32'd20);
        check({tag, "_init_start"}, rise_at(1) - t_rst_rise, 32'd0);
        for (int k = 1; k < 4; k++) begin
            check($sformatf("%s_req_len%0d", tag, k), fall_at(k) - rise_at(k), 32'd4);
            check($sformatf("%s_req_gap%0d", tag, k), rise_at(k + 1) - fall_at(k), 32'd1);
        end
        check({tag, "_f1_to_vbat"}, t_vbat_fall - rise_at(4), 32'd5);
        check({tag, "_vbat_wait"}, rise_at(5) - t_vbat_fall, 32'd30);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        clear_log();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_pins", {26'd0, oled_vddc, oled_vbatc, oled_reset, oled_dc, spi_req, spi_own},
              32'b111000);
        check("rst_status", rd_data, 32'h0);
        check("rst_byte", {24'd0, spi_byte}, 32'h0);

        // Power-on with a stray ack, a rejected CTRL and a DC write mid-sequence.
        clear_log();
        wr(5'd0, 32'h1);
        check("on_vdd_fall", {31'd0, oled_vddc}, 32'd0);
        check("on_own", {31'd0, spi_own}, 32'd1);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        wait_state("wait_vbat", 4'd5, 300);
        wr(5'd1, 32'h1);
        wr(5'd0, 32'h1);
        check("mid_dc", {31'd0, oled_dc}, 32'd0);
        check("mid_status", rd_data, 32'h505);
        wait_state("wait_on1", 4'd7, 300);
        check_on_bytes("on1");
        check_on_timing("on1");
        check("on1_status", rd_data, 32'h607);
        check("on1_pins", {26'd0, oled_vddc, oled_vbatc, oled_reset, oled_dc, spi_req, spi_own},
              32'b001000);
        wr(5'd2, 32'h0);
        check("clr_status", rd_data, 32'h207);
        wr(5'd1, 32'h1);
        check("on_dc_set", {31'd0, oled_dc}, 32'd1);

        // Power-off from ON.
        clear_log();
        wr(5'd0, 32'h2);
        wait_state("wait_off", 4'd0, 300);
        check("off_nbytes", q_byte.size(), 32'd1);
        check("off_byte", byte_at(0), 32'hAE);
        check("off_dc_at_req", (q_dc.size() > 0) ? q_dc[0] : -1, 32'd0);
        check("off_ae_to_vbat", t_vbat_rise - rise_at(0), 32'd5);
        check("off_vbat_wait", t_vdd_rise - t_vbat_rise, 32'd30);
        check("off_status", rd_data, 32'h0);
        check("off_pins", {26'd0, oled_vddc, oled_vbatc, oled_reset, oled_dc, spi_req, spi_own},
              32'b111000);

        // Rejections in OFF, including both CTRL bits set.
        wr(5'd0, 32'h2);
        check("rej_off_in_off", rd_data, 32'h400);
        wr(5'd2, 32'h0);
        check("rej_clear", rd_data, 32'h0);
        wr(5'd0, 32'h3);
        check("rej_both_bits", rd_data, 32'h400);
        wr(5'd2, 32'h0);

        // Power-on with the ack for 0x14 withheld.
        clear_log();
        slow_14 = 1'b1;
        wr(5'd0, 32'h1);
        n = 0;
        while (!(spi_req === 1'b1 && spi_byte === 8'h14) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_14", {23'd0, spi_req, spi_byte}, {23'd0, 1'b1, 8'h14});
        bad = 0;
        repeat (45) begin
            @(negedge clk);
            if (spi_req !== 1'b1 || spi_byte !== 8'h14) bad++;
        end
        check("hold_14", bad, 32'd0);
        wait_state("wait_on2", 4'd7, 600);
        slow_14 = 1'b0;
        check_on_bytes("on2");
        check("slow_14_len", fall_at(2) - rise_at(2), 32'd50);

        // Reset from ON, then reset in the middle of RST_LOW.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_from_on", rd_data, 32'h0);
        wr(5'd0, 32'h1);
        wait_state("wait_rst_low", 4'd3, 300);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_pins", {26'd0, oled_vddc, oled_vbatc, oled_reset, oled_dc, spi_req, spi_own},
              32'b111000);
        check("midrst_status", rd_data, 32'h0);
        check("midrst_byte", {24'd0, spi_byte}, 32'h0);
        reset = 1'b0;
        clear_log();
        wr(5'd0, 32'h1);
        wait_state("wait_on3", 4'd7, 300);
        check_on_bytes("on3");
        check_on_timing("on3");
        check("on3_status", rd_data, 32'h207);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
